// File: rtl/cdb_arbiter.sv
// Common-data-bus arbiter: grants up to two of NREQ completion requesters per
// cycle in round-robin order and registers the winners onto two CDB slots.
module cdb_arbiter #(
  parameter  int unsigned NREQ = 4,
  parameter  int unsigned BITS = 4,
  localparam int unsigned PW   = $clog2(NREQ)
) (
  input  logic                 clk_in,
  input  logic                 rst_in,
  input  logic                 rdy_in,
  input  logic                 flush,
  input  logic [NREQ-1:0]      req_valid,
  input  logic [NREQ*BITS-1:0] req_id,
  input  logic [NREQ*32-1:0]   req_value,
  output logic [NREQ-1:0]      req_ready,
  output logic                 cdb_rdy_1,
  output logic [BITS-1:0]      cdb_id_1,
  output logic [31:0]          cdb_value_1,
  output logic                 cdb_rdy_2,
  output logic [BITS-1:0]      cdb_id_2,
  output logic [31:0]          cdb_value_2,
  output logic [PW-1:0]        rr_ptr
);

  logic [BITS-1:0] ids  [NREQ];
  logic [31:0]     vals [NREQ];
  logic            a_found, b_found;
  logic [PW-1:0]   a_idx, b_idx, last_idx, ptr_next;
  logic [NREQ-1:0] grant;

  always_comb begin
    for (int unsigned i = 0; i < NREQ; i++) begin
      ids[i]  = req_id[i*BITS +: BITS];
      vals[i] = req_value[i*32 +: 32];
    end
  end

  // Rotating scan from rr_ptr; index wraps explicitly so non-power-of-two
  // NREQ never selects an out-of-range requester.
  always_comb begin
    int unsigned k;
    logic [PW-1:0] idx;
    grant   = '0;
    a_found = 1'b0;
    b_found = 1'b0;
    a_idx   = '0;
    b_idx   = '0;
    k       = 0;
    idx     = '0;
    if (!rst_in && !flush && rdy_in) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        k = 32'(rr_ptr) + i;
        if (k >= NREQ) k = k - NREQ;
        idx = PW'(k);
        if (req_valid[idx]) begin
          if (!a_found) begin
            a_found    = 1'b1;
            a_idx      = idx;
            grant[idx] = 1'b1;
          end else if (!b_found) begin
            b_found    = 1'b1;
            b_idx      = idx;
            grant[idx] = 1'b1;
          end
        end
      end
    end
  end

  always_comb begin
    last_idx = b_found ? b_idx : a_idx;
    ptr_next = (last_idx == PW'(NREQ - 1)) ? '0 : last_idx + 1'b1;
  end

  assign req_ready = grant;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cdb_rdy_1   <= 1'b0;
      cdb_id_1    <= '0;
      cdb_value_1 <= '0;
      cdb_rdy_2   <= 1'b0;
      cdb_id_2    <= '0;
      cdb_value_2 <= '0;
      rr_ptr      <= '0;
    end else if (flush) begin
      cdb_rdy_1 <= 1'b0;
      cdb_rdy_2 <= 1'b0;
      rr_ptr    <= '0;
    end else if (rdy_in) begin
      cdb_rdy_1 <= a_found;
      cdb_rdy_2 <= b_found;
      if (a_found) begin
        cdb_id_1    <= ids[a_idx];
        cdb_value_1 <= vals[a_idx];
        rr_ptr      <= ptr_next;
      end
      if (b_found) begin
        cdb_id_2    <= ids[b_idx];
        cdb_value_2 <= vals[b_idx];
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter: hand-built vector table for the named scenarios, then
// random traffic checked against a queue-based round-robin reference model.
module tb_cdb_arbiter;
  localparam int NREQ = 4;
  localparam int BITS = 4;

  logic                 clk = 1'b0;
  logic                 rst, flush, rdy;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*BITS-1:0] req_id;
  logic [NREQ*32-1:0]   req_value;
  logic [NREQ-1:0]      req_ready;
  logic                 cdb_rdy_1, cdb_rdy_2;
  logic [BITS-1:0]      cdb_id_1, cdb_id_2;
  logic [31:0]          cdb_value_1, cdb_value_2;
  logic [1:0]           rr_ptr;

  cdb_arbiter #(.NREQ(NREQ), .BITS(BITS)) dut (
    .clk_in(clk), .rst_in(rst), .rdy_in(rdy), .flush(flush),
    .req_valid(req_valid), .req_id(req_id), .req_value(req_value),
    .req_ready(req_ready),
    .cdb_rdy_1(cdb_rdy_1), .cdb_id_1(cdb_id_1), .cdb_value_1(cdb_value_1),
    .cdb_rdy_2(cdb_rdy_2), .cdb_id_2(cdb_id_2), .cdb_value_2(cdb_value_2),
    .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, flush, rdy;
    logic [3:0]  valid;
    logic [15:0] ids;
    logic [31:0] base;
    logic [3:0]  ready;
    logic        r1;
    logic [3:0]  id1;
    logic [31:0] v1;
    logic        r2;
    logic [3:0]  id2;
    logic [31:0] v2;
    logic [1:0]  ptr;
  } vec_t;

  int nvec = 0;
  int nfail = 0;

  // Reference model state
  int          m_ptr = 0;
  logic        m_r1 = 0, m_r2 = 0;
  logic [3:0]  m_id1 = 0, m_id2 = 0;
  logic [31:0] m_v1 = 0, m_v2 = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic apply(input vec_t v, input bit from_model);
    int q[$];
    logic [3:0] m_ready;
    @(negedge clk);
    rst = v.rst; flush = v.flush; rdy = v.rdy;
    req_valid = v.valid; req_id = v.ids;
    for (int i = 0; i < NREQ; i++) req_value[i*32 +: 32] = v.base + 32'(i);

    // Winners: first two valid requesters met walking round from the pointer
    q = {};
    if (!v.rst && !v.flush && v.rdy)
      for (int off = 0; off < NREQ; off++) begin
        int idx;
        idx = (m_ptr + off) % NREQ;
        if (v.valid[idx] && q.size() < 2) q.push_back(idx);
      end
    m_ready = '0;
    foreach (q[k]) m_ready[q[k]] = 1'b1;

    if (v.rst) begin
      m_r1 = 0; m_r2 = 0; m_id1 = 0; m_id2 = 0; m_v1 = 0; m_v2 = 0; m_ptr = 0;
    end else if (v.flush) begin
      m_r1 = 0; m_r2 = 0; m_ptr = 0;
    end else if (v.rdy) begin
      m_r1 = (q.size() > 0);
      m_r2 = (q.size() > 1);
      if (m_r1) begin
        m_id1 = v.ids[q[0]*4 +: 4];
        m_v1  = v.base + 32'(q[0]);
        m_ptr = (q[q.size()-1] + 1) % NREQ;
      end
      if (m_r2) begin
        m_id2 = v.ids[q[1]*4 +: 4];
        m_v2  = v.base + 32'(q[1]);
      end
    end

    if (from_model) begin
      v.ready = m_ready; v.r1 = m_r1; v.id1 = m_id1; v.v1 = m_v1;
      v.r2 = m_r2; v.id2 = m_id2; v.v2 = m_v2; v.ptr = 2'(m_ptr);
    end

    #1 chk("req_ready", 32'(req_ready), 32'(v.ready));
    @(posedge clk);
    #1;
    chk("cdb_rdy_1", 32'(cdb_rdy_1), 32'(v.r1));
    chk("cdb_rdy_2", 32'(cdb_rdy_2), 32'(v.r2));
    chk("rr_ptr", 32'(rr_ptr), 32'(v.ptr));
    if (v.r1 || v.rst) begin
      chk("cdb_id_1", 32'(cdb_id_1), 32'(v.id1));
      chk("cdb_value_1", cdb_value_1, v.v1);
    end
    if (v.r2 || v.rst) begin
      chk("cdb_id_2", 32'(cdb_id_2), 32'(v.id2));
      chk("cdb_value_2", cdb_value_2, v.v2);
    end
  endtask

  vec_t tbl[20];

  initial begin
    rst = 1; flush = 0; rdy = 1; req_valid = '0; req_id = '0; req_value = '0;

    // rst flush rdy valid ids base | ready r1 id1 v1 r2 id2 v2 ptr
    tbl[0]  = '{1,0,1,4'b0000,16'h0000,32'h0,          4'b0000,0,0,32'h0,0,0,32'h0,0};
    tbl[1]  = '{0,0,1,4'b0000,16'h0000,32'h0,          4'b0000,0,0,32'h0,0,0,32'h0,0};
    tbl[2]  = '{0,0,1,4'b0000,16'h0000,32'h0,          4'b0000,0,0,32'h0,0,0,32'h0,0};
    tbl[3]  = '{0,0,1,4'b0000,16'h0000,32'h0,          4'b0000,0,0,32'h0,0,0,32'h0,0};
    // single request from requester 2
    tbl[4]  = '{0,0,1,4'b0100,16'h0300,32'hDEADBEED,   4'b0100,1,3,32'hDEADBEEF,0,0,32'h0,3};
    tbl[5]  = '{0,0,1,4'b0000,16'h0000,32'h0,          4'b0000,0,0,32'h0,0,0,32'h0,3};
    // wrap-around from pointer 3
    tbl[6]  = '{0,0,1,4'b1001,16'h9007,32'h10000000,   4'b1001,1,9,32'h10000003,1,7,32'h10000000,1};
    // grant at T, flush at T+1
    tbl[7]  = '{0,0,1,4'b1111,16'h4321,32'h20000000,   4'b0110,1,2,32'h20000001,1,3,32'h20000002,3};
    tbl[8]  = '{0,1,1,4'b1111,16'h4321,32'h20000000,   4'b0000,0,0,32'h0,0,0,32'h0,0};
    // full contention
    tbl[9]  = '{0,0,1,4'b1111,16'h4321,32'h20000000,   4'b0011,1,1,32'h20000000,1,2,32'h20000001,2};
    tbl[10] = '{0,0,1,4'b1111,16'h4321,32'h20000000,   4'b1100,1,3,32'h20000002,1,4,32'h20000003,0};
    tbl[11] = '{0,0,1,4'b1111,16'h4321,32'h20000000,   4'b0011,1,1,32'h20000000,1,2,32'h20000001,2};
    // slot 1 carries id 5, then pause three cycles
    tbl[12] = '{0,0,1,4'b0100,16'h0500,32'h30000000,   4'b0100,1,5,32'h30000002,0,0,32'h0,3};
    tbl[13] = '{0,0,0,4'b1111,16'h4321,32'h20000000,   4'b0000,1,5,32'h30000002,0,0,32'h0,3};
    tbl[14] = '{0,0,0,4'b1111,16'h4321,32'h20000000,   4'b0000,1,5,32'h30000002,0,0,32'h0,3};
    tbl[15] = '{0,0,0,4'b1111,16'h4321,32'h20000000,   4'b0000,1,5,32'h30000002,0,0,32'h0,3};
    tbl[16] = '{0,0,1,4'b1111,16'h4321,32'h20000000,   4'b1001,1,4,32'h20000003,1,1,32'h20000000,1};
    // reset beats pending traffic
    tbl[17] = '{1,0,1,4'b1111,16'h4321,32'h20000000,   4'b0000,0,0,32'h0,0,0,32'h0,0};
    // flush wins over rdy_in=0
    tbl[18] = '{0,0,1,4'b0001,16'h0006,32'h40000000,   4'b0001,1,6,32'h40000000,0,0,32'h0,1};
    tbl[19] = '{0,1,0,4'b0001,16'h0006,32'h40000000,   4'b0000,0,0,32'h0,0,0,32'h0,0};

    foreach (tbl[i]) apply(tbl[i], 1'b0);

    for (int n = 0; n < 400; n++) begin
      vec_t v;
      v = tbl[0];
      v.rst   = ($urandom_range(0, 99) == 0);
      v.flush = ($urandom_range(0, 99) < 4);
      v.rdy   = ($urandom_range(0, 99) < 85);
      v.valid = 4'($urandom);
      v.ids   = 16'($urandom);
      v.base  = $urandom & 32'hFFFF_FFF0;
      apply(v, 1'b1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Shares the reorder buffer's two finish/broadcast write ports among NREQ execution-unit completion requesters: ALUs, load/store buffer, branch unit.
- Grants up to two requesters per cycle in round-robin order.
- Registers the winners onto two common-data-bus slots. These drive the ROB finish inputs and the RS/LSB operand-wakeup inputs.
- Discards all in-flight results on a pipeline flush (ROB clear).

Parameters:
- NREQ, 4, number of completion requesters (2..8).
- BITS, 4, ROB index width (matches RoB_BITS).

Ports:
- clk_in  input  1  system clock
- rst_in  input  1  reset; synchronous, active-high
- rdy_in  input  1  global ready; pause when low
- flush  input  1  ROB clear/mispredict; squash everything
- req_valid  input  NREQ  requester i has a finished result
- req_id  input  NREQ*BITS  ROB index of requester i, slice [i*BITS +: BITS]
- req_value  input  NREQ*32  result of requester i, slice [i*32 +: 32]
- req_ready  output  NREQ  combinational grant; requester i's result is consumed this cycle
- cdb_rdy_1  output  1  slot-1 valid (registered)
- cdb_id_1  output  BITS  slot-1 ROB index
- cdb_value_1  output  32  slot-1 value
- cdb_rdy_2  output  1  slot-2 valid (registered)
- cdb_id_2  output  BITS  slot-2 ROB index
- cdb_value_2  output  32  slot-2 value
- rr_ptr  output  clog2(NREQ)  current round-robin start pointer (debug/verification)

Behaviour:
- Reset (rst_in=1 at posedge):
  - cdb_rdy_1/2=0, cdb_id_*=0, cdb_value_*=0, rr_ptr=0.
  - req_ready is forced all-0 while rst_in=1.
- Grant selection is combinational each cycle:
  - Scan requesters in order rr_ptr, rr_ptr+1, … mod NREQ.
  - First valid found = winner A; second valid found = winner B.
  - req_ready[A]=1 and req_ready[B]=1; all others 0.
  - Zero valids -> no grants. One valid -> only A granted.
- A requester holds req_valid/req_id/req_value stable until it sees req_ready=1 at a posedge. It may deassert only after the grant.
- Latency: a grant at posedge T appears on the CDB outputs during cycle T+1.
  - A -> slot 1, B -> slot 2.
  - A slot with no winner has cdb_rdy_*=0; its id/value hold the previous contents (don't-care).
- CDB outputs are valid for exactly one cycle per grant. cdb_rdy_* with no new grant drops to 0 at the next posedge.
- Pointer update on any cycle with at least one grant:
  - rr_ptr <= (last granted index + 1) mod NREQ, i.e. B+1 if B exists, else A+1.
  - No grants -> rr_ptr unchanged.
  - This guarantees no requester waits more than ceil((NREQ-1)/2) grant cycles.
- rdy_in=0:
  - req_ready all-0.
  - CDB registers and rr_ptr hold their values (including cdb_rdy_*); the ROB ignores them while paused.
- flush=1 (rdy_in don't-care):
  - req_ready all-0 that cycle.
  - At the posedge: cdb_rdy_1/2 <= 0, rr_ptr <= 0.
  - Requesters flush themselves, so nothing is buffered here.
- Priority: rst_in > flush > rdy_in.
- Duplicate req_id values across requesters are not checked; the issue logic guarantees uniqueness.
- NREQ not a power of two: pointer wraps explicitly at NREQ-1 -> 0, never to an invalid index.

Test Plan:
- Reset then idle: all req_valid=0 for 5 cycles -> cdb_rdy_1/2=0 throughout, rr_ptr=0, req_ready=0.
- Single request: req_valid=4'b0100, id=3, value=32'hDEAD_BEEF -> req_ready=4'b0100 same cycle. Next cycle cdb_rdy_1=1, cdb_id_1=3, cdb_value_1=32'hDEADBEEF, cdb_rdy_2=0. rr_ptr=3. Following cycle cdb_rdy_1=0.
- Full contention, NREQ=4, all valid every cycle:
  - Grants (0,1) with rr_ptr 0->2, then (2,3) with rr_ptr 2->0, then (0,1) again.
  - Each requester is granted every 2 cycles; slot ordering is as listed.
- Wrap-around: rr_ptr=3, req_valid=4'b1001 -> slot1 = requester 3, slot2 = requester 0; rr_ptr -> 1.
- Flush mid-traffic: a grant at cycle T with flush=1 at cycle T+1 -> CDB valid in T+1. In T+1, req_ready=0 despite pending valids. After the T+1 posedge: cdb_rdy_1/2=0, rr_ptr=0.
- rdy_in low: with CDB slot 1 valid (id=5), hold rdy_in=0 for 3 cycles -> req_ready=0, cdb_id_1 stays 5, cdb_rdy_1 stays 1, rr_ptr unchanged. Arbitration resumes the cycle rdy_in returns to 1.
